// File: rtl/countdown_if.sv
// Handshake bundle for countdown_timer: control inputs plus count/status outputs.
interface countdown_if;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       stop;
   logic [3:0] q;
   logic       busy;
   logic       tick;
   logic       done;

   modport master (output load, load_val, start, stop, input q, busy, tick, done);
   modport slave  (input load, load_val, start, stop, output q, busy, tick, done);
endinterface

// File: rtl/countdown_timer.sv
// Prescaled 4-bit countdown timer with one-cycle done pulse.
// Optional COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload the last loaded value and keep running.
module countdown_timer #(
   parameter int PRESCALE_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   countdown_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic [PRESCALE_W-1:0] pre;
   logic [3:0]            q;
   logic                  done;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [3:0]            reload;
`endif

   assign bus.q    = q;
   assign bus.done = done;
   assign bus.busy = (state == RUN);
   assign bus.tick = (state == RUN) && (&pre);

   // load > stop > start; a pending stop also masks start while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pre    <= '0;
         q      <= '0;
         done   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (bus.load) begin
            q      <= bus.load_val;
            state  <= IDLE;
            pre    <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= bus.load_val;
`endif
         end else if (bus.stop) begin
            state <= IDLE;
         end else if (state == IDLE) begin
            if (bus.start) begin
               if (q != 4'd0) begin
                  state <= RUN;
                  pre   <= '0;
               end else begin
                  done <= 1'b1;
               end
            end
         end else begin
            pre <= pre + 1'b1;
            if (&pre) begin
               if (q > 4'd1) begin
                  q <= q - 4'd1;
               end else begin
                  done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  if (reload != 4'd0) begin
                     q <= reload;
                  end else begin
                     q     <= 4'd0;
                     state <= IDLE;
                  end
`else
                  q     <= 4'd0;
                  state <= IDLE;
`endif
               end
            end
         end
      end
   end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: PRESCALE_W, default 4, prescaler width; one count step every 2**PRESCALE_W clk cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  when high, capture load_val into count and reload register.
REQ-005 load_val  input  4  value captured by load.
REQ-006 start  input  1  begin counting down from current count.
REQ-007 stop  input  1  abort counting; count holds.
REQ-008 q  output  4  current count, registered.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 tick  output  1  combinational; high in the RUN cycle whose edge applies a count step.
REQ-011 done  output  1  registered one-cycle pulse when count reaches zero.

Function
REQ-012 The FSM SHALL have states IDLE and RUN; busy = (state == RUN).
REQ-013 The PRESCALE_W-bit prescaler SHALL clear to 0 on any load and on the start edge, increment every cycle in RUN, and hold in IDLE.
REQ-014 tick SHALL be high exactly when state == RUN and prescaler == all ones.
REQ-015 Priority SHALL be load > stop > start when several are high in the same cycle.
REQ-016 load, in any state: q <= load_val, reload <= load_val, state <= IDLE, prescaler <= 0, done <= 0.
REQ-017 stop in RUN (no load): state <= IDLE, q and prescaler hold, done <= 0; stop in IDLE has no effect.
REQ-018 start in IDLE with q != 0: state <= RUN, prescaler <= 0; start in IDLE with q == 0: state stays IDLE, done <= 1 for one cycle.
REQ-019 start while in RUN SHALL be ignored, and the prescaler SHALL NOT restart.
REQ-020 On tick with q > 1: q <= q - 1 and state stays RUN.
REQ-021 On tick with q == 1: q <= 0, done <= 1, state <= IDLE (see REQ-027 for the AUTO_RELOAD_EN variant).
REQ-022 q SHALL never wrap below 0; no decrement occurs in IDLE.
REQ-023 done SHALL be high for exactly one cycle per expiry and low in every other cycle.
REQ-024 Latency: from the start edge with q = N (N > 0), done is first high 2**PRESCALE_W * N cycles later (64 cycles for N = 4, PRESCALE_W = 4).

Reset
REQ-025 While rst is high, regardless of clk: q = 0, reload = 0, prescaler = 0, state = IDLE, done = 0, busy = 0, tick = 0.
REQ-026 Reset asserted mid-count SHALL abort immediately; after release the block stays IDLE until start or load.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on tick with q == 1 and reload != 0, q <= reload, done <= 1, state stays RUN, and the prescaler keeps running.
- Defined with reload == 0: behave as REQ-021.
- Undefined: REQ-021 applies unconditionally, and the reload register may be omitted.

Verification
REQ-028 Reset release; load_val = 3 with load; start -> q: 3, 2, 1, 0 at 16-cycle spacing; done pulses once, 48 cycles after the start edge; busy then falls.
REQ-029 q = 5, start, stop asserted 40 cycles later -> q = 3, busy = 0; a second start -> done 48 cycles after the restart edge.
REQ-030 load, stop and start high together while in RUN -> q = load_val, state IDLE, no done pulse.
REQ-031 q = 0 with start -> single done pulse; busy stays 0; q stays 0.
REQ-032 rst pulsed high, between edges, 20 cycles into a count of 9 -> all outputs 0 at once; no done after release.
REQ-033 With COUNTDOWN_AUTO_RELOAD_EN defined: load 2, start -> done pulses every 32 cycles; q cycles 2, 1, 2, 1; stop ends the run.
